trap_ctrl: RTL and testbench

//   Sequences machine-mode trap entry and MRET return around the csr block.

---
 rtl/trap_ctrl.sv | 178 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / MRET return sequencer: arbitrates exceptions, MRET and
// interrupts, drains the pipeline, strobes the csr updates, then redirects fetch.
module trap_ctrl #(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            exc_valid,
   input  logic [4:0]      exc_cause,
   input  logic [XLEN-1:0] exc_pc,
   input  logic            mret_valid,
   input  logic            commit_valid,
   input  logic [XLEN-1:0] commit_next_pc,
   input  logic            irq_ext,
   input  logic            irq_timer,
   input  logic            irq_sw,
   input  logic            mstatus_mie,
   input  logic [2:0]      mie_en,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   output logic [2:0]      mip,
   output logic            trap_take,
   output logic [XLEN-1:0] trap_epc,
   output logic [XLEN-1:0] trap_cause,
   output logic            mret_take,
   output logic            flush,
   output logic            stall,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
   typedef enum logic [1:0] {K_EXC, K_MRET, K_IRQ} kind_t;

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   state_t          state, state_nxt;
   kind_t           kind_r;
   logic [3:0]      code_r;
   logic [3:0]      cnt_r;
   logic [XLEN-1:0] epc_r, cause_r, pc_r;
   logic            ext_m, ext_s, timer_r, sw_r;
   logic [2:0]      pend;
   logic            irq_ok, accept;
   logic [3:0]      irq_code;

   function automatic logic [XLEN-1:0] target_pc(
      input kind_t kind, input logic [3:0] code,
      input logic [XLEN-1:0] tvec, input logic [XLEN-1:0] epc);
      logic [XLEN-1:0] base;
      base = tvec & ALIGN_MASK;
      if (kind == K_MRET)
         target_pc = epc & ALIGN_MASK;
      else if (kind == K_IRQ && tvec[1:0] == 2'b01)
         target_pc = base + {{(XLEN-6){1'b0}}, code, 2'b00};
      else
         target_pc = base;
   endfunction

   // ext is asynchronous and needs two flops; timer/sw are already in this domain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ext_m   <= 1'b0;
         ext_s   <= 1'b0;
         timer_r <= 1'b0;
         sw_r    <= 1'b0;
      end else begin
         ext_m   <= irq_ext;
         ext_s   <= ext_m;
         timer_r <= irq_timer;
         sw_r    <= irq_sw;
      end
   end

   assign mip    = {ext_s, timer_r, sw_r};
   assign pend   = mip & mie_en;
   assign irq_ok = (state == IDLE) && commit_valid && mstatus_mie && (|pend);
   assign accept = (state == IDLE) && (exc_valid || mret_valid || irq_ok);

   always_comb begin
      irq_code = 4'd7;
      if (pend[2])      irq_code = 4'd11;
      else if (pend[0]) irq_code = 4'd3;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (accept) state_nxt = DRAIN;
         DRAIN:    if (cnt_r == 4'd0) state_nxt = COMMIT;
         COMMIT:   state_nxt = REDIRECT;
         REDIRECT: state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         kind_r  <= K_EXC;
         code_r  <= 4'd0;
         cnt_r   <= 4'd0;
         epc_r   <= '0;
         cause_r <= '0;
         pc_r    <= '0;
      end else begin
         if (accept) begin
            cnt_r <= 4'(FLUSH_CYCLES - 1);
            if (exc_valid) begin
               kind_r  <= K_EXC;
               code_r  <= 4'd0;
               epc_r   <= exc_pc;
               cause_r <= {{(XLEN-5){1'b0}}, exc_cause};
            end else if (mret_valid) begin
               kind_r  <= K_MRET;
               code_r  <= 4'd0;
               epc_r   <= '0;
               cause_r <= '0;
            end else begin
               kind_r  <= K_IRQ;
               code_r  <= irq_code;
               epc_r   <= commit_next_pc;
               cause_r <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
            end
         end else if (state == DRAIN && cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
         end
         // csr writes have settled by COMMIT, so the vector/return PC is taken here
         if (state == COMMIT)
            pc_r <= target_pc(kind_r, code_r, mtvec, mepc);
      end
   end

   always_comb begin
      flush          = 1'b0;
      stall          = 1'b0;
      busy           = 1'b0;
      trap_take      = 1'b0;
      mret_take      = 1'b0;
      redirect_valid = 1'b0;
      trap_epc       = '0;
      trap_cause     = '0;
      redirect_pc    = '0;
      unique case (state)
         IDLE: ;
         DRAIN: begin
            flush = 1'b1;
            stall = 1'b1;
            busy  = 1'b1;
         end
         COMMIT: begin
            stall = 1'b1;
            busy  = 1'b1;
            if (kind_r == K_MRET) begin
               mret_take = 1'b1;
            end else begin
               trap_take  = 1'b1;
               trap_epc   = epc_r;
               trap_cause = cause_r;
            end
         end
         REDIRECT: begin
            stall          = 1'b1;
            busy           = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = pc_r;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed events push expected strobes, a monitor
// pops and compares them whenever the DUT raises trap_take, mret_take or redirect_valid.
module tb_trap_ctrl;
   localparam int XLEN = 32;
   localparam int FC   = 2;

   logic            clk, reset_n;
   logic            exc_valid, mret_valid, commit_valid;
   logic [4:0]      exc_cause;
   logic [XLEN-1:0] exc_pc, commit_next_pc, mtvec, mepc;
   logic            irq_ext, irq_timer, irq_sw, mstatus_mie;
   logic [2:0]      mie_en, mip;
   logic            trap_take, mret_take, flush, stall, redirect_valid, busy;
   logic [XLEN-1:0] trap_epc, trap_cause, redirect_pc;

   trap_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .reset_n(reset_n),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
      .mret_valid(mret_valid), .commit_valid(commit_valid),
      .commit_next_pc(commit_next_pc),
      .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
      .mstatus_mie(mstatus_mie), .mie_en(mie_en), .mtvec(mtvec), .mepc(mepc),
      .mip(mip), .trap_take(trap_take), .trap_epc(trap_epc), .trap_cause(trap_cause),
      .mret_take(mret_take), .flush(flush), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
   );

   typedef struct {
      int          kind;   // 0 trap_take, 1 mret_take, 2 redirect_valid
      logic [31:0] a;
      logic [31:0] b;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   // Called at the negedge where the event is driven; acceptance is the next posedge.
   task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause,
                            input logic [31:0] rpc);
      q.push_back('{kind: 0, a: epc, b: cause, cyc: cyc + 1 + FC});
      q.push_back('{kind: 2, a: rpc, b: 32'h0, cyc: cyc + 2 + FC});
   endtask

   task automatic push_mret(input logic [31:0] rpc);
      q.push_back('{kind: 1, a: 32'h0, b: 32'h0, cyc: cyc + 1 + FC});
      q.push_back('{kind: 2, a: rpc, b: 32'h0, cyc: cyc + 2 + FC});
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", {31'b0, busy}, 32'h0);
   endtask

   exp_t e;
   int   got_kind;
   always begin
      @(posedge clk);
      #1;
      if (trap_take || mret_take || redirect_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_strobe", {29'b0, trap_take, mret_take, redirect_valid}, 32'h0);
         end else begin
            e = q.pop_front();
            got_kind = trap_take ? 0 : (mret_take ? 1 : 2);
            chk("strobe_kind", got_kind, e.kind);
            chk("strobe_cycle", cyc, e.cyc);
            if (e.kind == 0) begin
               chk("trap_epc", trap_epc, e.a);
               chk("trap_cause", trap_cause, e.b);
            end else if (e.kind == 2) begin
               chk("redirect_pc", redirect_pc, e.a);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 0; exc_valid = 0; exc_cause = 0; exc_pc = 0; mret_valid = 0;
      commit_valid = 0; commit_next_pc = 0; irq_ext = 0; irq_timer = 0; irq_sw = 0;
      mstatus_mie = 0; mie_en = 0; mtvec = 32'h800; mepc = 0;
      repeat (2) @(negedge clk);
      chk("reset_ctrl", {26'b0, busy, flush, stall, trap_take, mret_take, redirect_valid}, 32'h0);
      chk("reset_mip", {29'b0, mip}, 32'h0);
      chk("reset_redirect_pc", redirect_pc, 32'h0);
      reset_n = 1;
      @(negedge clk);

      // 1: illegal-instruction exception, direct vector
      exc_valid = 1; exc_cause = 5'd2; exc_pc = 32'h100; mtvec = 32'h800;
      push_trap(32'h100, 32'h2, 32'h800);
      @(negedge clk); exc_valid = 0;
      chk("drain_flush_1", {31'b0, flush}, 32'h1);
      @(negedge clk);
      chk("drain_flush_2", {31'b0, flush}, 32'h1);
      @(negedge clk);
      chk("commit_flush_stall", {30'b0, flush, stall}, 32'h1);
      wait_idle();

      // 2: external interrupt through the synchroniser, vectored
      mstatus_mie = 1; mie_en = 3'b100; irq_ext = 1; commit_valid = 0;
      mtvec = 32'h801; commit_next_pc = 32'h204;
      repeat (3) @(negedge clk);
      chk("mip_ext", {29'b0, mip}, 32'h4);
      commit_valid = 1;
      push_trap(32'h204, 32'h8000000B, 32'h82C);
      @(negedge clk); commit_valid = 0; mstatus_mie = 0; irq_ext = 0;
      wait_idle();

      // 3: exception beats timer; timer taken back-to-back after REDIRECT
      irq_timer = 1; mie_en = 3'b010; mstatus_mie = 1; mtvec = 32'h801;
      repeat (2) @(negedge clk);
      exc_valid = 1; exc_cause = 5'd5; exc_pc = 32'h300;
      commit_valid = 1; commit_next_pc = 32'h304;
      push_trap(32'h300, 32'h5, 32'h800);
      @(negedge clk); exc_valid = 0; mstatus_mie = 0; commit_valid = 0;
      wait_idle();
      mstatus_mie = 1; commit_valid = 1; commit_next_pc = 32'h400;
      push_trap(32'h400, 32'h80000007, 32'h81C);
      @(negedge clk); mstatus_mie = 0; commit_valid = 0; irq_timer = 0;
      wait_idle();

      // 4: MRET aligns mepc
      mtvec = 32'h800; mepc = 32'h1003; mret_valid = 1;
      push_mret(32'h1000);
      @(negedge clk); mret_valid = 0;
      wait_idle();

      // 5: pending sw irq held off by MIE=0, then by commit_valid=0
      irq_sw = 1; mie_en = 3'b001; mstatus_mie = 0; commit_valid = 1;
      repeat (4) begin
         @(negedge clk);
         chk("blocked_mie", {31'b0, busy}, 32'h0);
      end
      mstatus_mie = 1; commit_valid = 0;
      repeat (3) begin
         @(negedge clk);
         chk("blocked_commit", {31'b0, busy}, 32'h0);
      end
      mstatus_mie = 0;

      // 7: ext beats sw; vectored target wraps past 2^32
      irq_ext = 1; mie_en = 3'b101; mtvec = 32'hFFFF_FFFD; commit_next_pc = 32'h500;
      mstatus_mie = 1;
      repeat (3) @(negedge clk);
      commit_valid = 1;
      push_trap(32'h500, 32'h8000000B, 32'h28);
      @(negedge clk); commit_valid = 0; mstatus_mie = 0; irq_ext = 0;
      wait_idle();

      // 8: sw beats timer; reserved mode 11 behaves as direct
      irq_sw = 1; irq_timer = 1; mie_en = 3'b011; mtvec = 32'h803;
      commit_next_pc = 32'h600; mstatus_mie = 1;
      repeat (3) @(negedge clk);
      commit_valid = 1;
      push_trap(32'h600, 32'h80000003, 32'h800);
      @(negedge clk); commit_valid = 0; mstatus_mie = 0; irq_sw = 0; irq_timer = 0;
      wait_idle();
      repeat (2) @(negedge clk);

      // 6: reset during DRAIN aborts with no later strobe
      mtvec = 32'h800; exc_valid = 1; exc_cause = 5'd2; exc_pc = 32'h700;
      @(negedge clk); exc_valid = 0;
      chk("pre_reset_flush", {31'b0, flush}, 32'h1);
      reset_n = 0;
      #1;
      chk("async_reset_ctrl", {28'b0, busy, flush, stall, trap_take}, 32'h0);
      @(negedge clk); reset_n = 1;
      repeat (6) begin
         @(negedge clk);
         chk("post_reset_idle", {31'b0, busy}, 32'h0);
      end

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
